// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between two requesters (core, net), the data-memory
// arbiter and the data memory. The arbiter attaches through the slave modport.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              core_valid_i;
    logic              core_wen_i;
    logic              core_byte_i;
    logic [ADDR_W-1:0] core_addr_i;
    logic [31:0]       core_wdata_i;
    logic              core_ack_o;
    logic              core_rvalid_o;
    logic [31:0]       core_rdata_o;

    logic              net_valid_i;
    logic              net_wen_i;
    logic              net_byte_i;
    logic [ADDR_W-1:0] net_addr_i;
    logic [31:0]       net_wdata_i;
    logic              net_ack_o;
    logic              net_rvalid_o;
    logic [31:0]       net_rdata_o;

    logic              mem_valid_o;
    logic              mem_wen_o;
    logic              mem_byte_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_yumi_i;
    logic              mem_rvalid_i;
    logic [31:0]       mem_rdata_i;
    logic              mem_yumi_o;

    modport slave (
        input  core_valid_i, core_wen_i, core_byte_i, core_addr_i, core_wdata_i,
        output core_ack_o, core_rvalid_o, core_rdata_o,
        input  net_valid_i, net_wen_i, net_byte_i, net_addr_i, net_wdata_i,
        output net_ack_o, net_rvalid_o, net_rdata_o,
        output mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o,
        input  mem_yumi_i, mem_rvalid_i, mem_rdata_i,
        output mem_yumi_o
    );

    modport master (
        output core_valid_i, core_wen_i, core_byte_i, core_addr_i, core_wdata_i,
        input  core_ack_o, core_rvalid_o, core_rdata_o,
        output net_valid_i, net_wen_i, net_byte_i, net_addr_i, net_wdata_i,
        input  net_ack_o, net_rvalid_o, net_rdata_o,
        input  mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o,
        output mem_yumi_i, mem_rvalid_i, mem_rdata_i,
        input  mem_yumi_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between core and net,
// one outstanding transaction at a time, with a sticky response-timeout flag.
module dmem_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus,
    output logic           busy_o,
    output logic           owner_o,
    output logic           err_o
);
    typedef enum logic [1:0] {
        DMEM_IDLE      = 2'd0,
        DMEM_REQ_SENT  = 2'd1,
        DMEM_REQ_ACKED = 2'd2
    } dmem_req_state_e;

    localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

    dmem_req_state_e   state_q;
    logic              last_grant_q;   // 1 = net was granted last
    logic              owner_q;
    logic              wen_q;
    logic              byte_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [7:0]        wait_cnt_q;
    logic [7:0]        wait_cnt_d;
    logic              err_q;

    logic              grant_s;
    logic              grant_net_s;
    logic              resp_s;

    // Same-cycle grant decision; a tie goes to whoever did not win last time.
    always_comb begin
        grant_s     = 1'b0;
        grant_net_s = 1'b0;
        if ((state_q == DMEM_IDLE) && !reset) begin
            if (bus.core_valid_i && bus.net_valid_i) begin
                grant_s     = 1'b1;
                grant_net_s = ~last_grant_q;
            end else if (bus.core_valid_i) begin
                grant_s     = 1'b1;
                grant_net_s = 1'b0;
            end else if (bus.net_valid_i) begin
                grant_s     = 1'b1;
                grant_net_s = 1'b1;
            end else begin
                grant_s     = 1'b0;
                grant_net_s = 1'b0;
            end
        end else begin
            grant_s     = 1'b0;
            grant_net_s = 1'b0;
        end
    end

    // Saturating next value of the response wait counter.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (wait_cnt_q == 8'hFF) begin
            wait_cnt_d = 8'hFF;
        end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    assign resp_s = (state_q == DMEM_REQ_ACKED) && bus.mem_rvalid_i && !reset;

    // Transaction FSM with command capture, wait counter and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= DMEM_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            wen_q        <= 1'b0;
            byte_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0000_0000;
            wait_cnt_q   <= 8'd0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                DMEM_IDLE: begin
                    if (grant_s) begin
                        state_q      <= DMEM_REQ_SENT;
                        owner_q      <= grant_net_s;
                        last_grant_q <= grant_net_s;
                        wen_q        <= grant_net_s ? bus.net_wen_i   : bus.core_wen_i;
                        byte_q       <= grant_net_s ? bus.net_byte_i  : bus.core_byte_i;
                        addr_q       <= grant_net_s ? bus.net_addr_i  : bus.core_addr_i;
                        wdata_q      <= grant_net_s ? bus.net_wdata_i : bus.core_wdata_i;
                    end else begin
                        state_q <= DMEM_IDLE;
                    end
                end
                DMEM_REQ_SENT: begin
                    // A response seen together with yumi is ignored; memory repeats it.
                    if (bus.mem_yumi_i) begin
                        state_q    <= DMEM_REQ_ACKED;
                        wait_cnt_q <= 8'd0;
                    end else begin
                        state_q <= DMEM_REQ_SENT;
                    end
                end
                DMEM_REQ_ACKED: begin
                    if (bus.mem_rvalid_i) begin
                        state_q <= DMEM_IDLE;
                    end else begin
                        state_q    <= DMEM_REQ_ACKED;
                        wait_cnt_q <= wait_cnt_d;
                        if (wait_cnt_d == TIMEOUT_C) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q <= err_q;
                        end
                    end
                end
                default: begin
                    state_q <= DMEM_IDLE;
                end
            endcase
        end
    end

    assign bus.core_ack_o    = grant_s & ~grant_net_s;
    assign bus.net_ack_o     = grant_s &  grant_net_s;

    assign bus.core_rvalid_o = resp_s & ~owner_q;
    assign bus.net_rvalid_o  = resp_s &  owner_q;
    assign bus.core_rdata_o  = bus.core_rvalid_o ? bus.mem_rdata_i : 32'h0000_0000;
    assign bus.net_rdata_o   = bus.net_rvalid_o  ? bus.mem_rdata_i : 32'h0000_0000;
    assign bus.mem_yumi_o    = resp_s;

    assign bus.mem_valid_o   = (state_q == DMEM_REQ_SENT);
    assign bus.mem_wen_o     = wen_q;
    assign bus.mem_byte_o    = byte_q;
    assign bus.mem_addr_o    = addr_q;
    assign bus.mem_wdata_o   = wdata_q;

    assign busy_o  = (state_q != DMEM_IDLE);
    assign owner_o = owner_q;
    assign err_o   = err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a transaction-level model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_dmem_arbiter;
    localparam int AW = 12;
    localparam int TO = 4;

    logic clk;
    logic reset;
    logic busy, owner, err;

    int checks = 0;
    int errors = 0;

    dmem_arbiter_if #(.ADDR_W(AW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .busy_o (busy),
        .owner_o(owner),
        .err_o  (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pick_net(input bit cv, input bit nv, input bit last_net);
        return (cv && nv) ? !last_net : nv;
    endfunction

    // ---------------- transaction-level model ----------------
    bit              m_on;
    bit              m_active;     // a transaction is in flight
    bit              m_accepted;   // memory has taken the command
    bit              m_owner;
    bit              m_last;
    bit              m_wen, m_byte;
    logic [AW-1:0]   m_addr;
    logic [31:0]     m_wdata;
    int              m_wait;
    bit              m_err;

    always @(posedge clk) begin
        if (reset) begin
            m_on <= 1'b1; m_active <= 1'b0; m_accepted <= 1'b0; m_owner <= 1'b0;
            m_last <= 1'b1; m_wen <= 1'b0; m_byte <= 1'b0; m_addr <= '0;
            m_wdata <= 32'h0; m_wait <= 0; m_err <= 1'b0;
        end else if (!m_active) begin
            if (bus.core_valid_i || bus.net_valid_i) begin
                m_active   <= 1'b1;
                m_accepted <= 1'b0;
                m_owner    <= pick_net(bus.core_valid_i, bus.net_valid_i, m_last);
                m_last     <= pick_net(bus.core_valid_i, bus.net_valid_i, m_last);
                if (pick_net(bus.core_valid_i, bus.net_valid_i, m_last)) begin
                    m_wen <= bus.net_wen_i; m_byte <= bus.net_byte_i;
                    m_addr <= bus.net_addr_i; m_wdata <= bus.net_wdata_i;
                end else begin
                    m_wen <= bus.core_wen_i; m_byte <= bus.core_byte_i;
                    m_addr <= bus.core_addr_i; m_wdata <= bus.core_wdata_i;
                end
            end
        end else if (!m_accepted) begin
            if (bus.mem_yumi_i) begin
                m_accepted <= 1'b1;
                m_wait     <= 0;
            end
        end else begin
            if (bus.mem_rvalid_i) begin
                m_active <= 1'b0;
            end else begin
                m_wait <= (m_wait >= 255) ? 255 : m_wait + 1;
                if (m_wait + 1 == TO) m_err <= 1'b1;
            end
        end
    end

    logic e_grant, e_gnet, e_resp;
    always @(negedge clk) begin
        if (m_on) begin
            e_grant = !m_active && !reset && (bus.core_valid_i || bus.net_valid_i);
            e_gnet  = pick_net(bus.core_valid_i, bus.net_valid_i, m_last);
            e_resp  = m_active && m_accepted && bus.mem_rvalid_i && !reset;
            chk("core_ack",    bus.core_ack_o,    32'(e_grant && !e_gnet));
            chk("net_ack",     bus.net_ack_o,     32'(e_grant && e_gnet));
            chk("core_rvalid", bus.core_rvalid_o, 32'(e_resp && !m_owner));
            chk("net_rvalid",  bus.net_rvalid_o,  32'(e_resp && m_owner));
            chk("core_rdata",  bus.core_rdata_o,  (e_resp && !m_owner) ? bus.mem_rdata_i : 32'h0);
            chk("net_rdata",   bus.net_rdata_o,   (e_resp && m_owner) ? bus.mem_rdata_i : 32'h0);
            chk("mem_yumi_o",  bus.mem_yumi_o,    32'(e_resp));
            chk("mem_valid",   bus.mem_valid_o,   32'(m_active && !m_accepted));
            chk("mem_wen",     bus.mem_wen_o,     32'(m_wen));
            chk("mem_byte",    bus.mem_byte_o,    32'(m_byte));
            chk("mem_addr",    32'(bus.mem_addr_o), 32'(m_addr));
            chk("mem_wdata",   bus.mem_wdata_o,   m_wdata);
            chk("busy",        busy,              32'(m_active));
            chk("owner",       owner,             32'(m_owner));
            chk("err",         err,               32'(m_err));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.core_valid_i = 1'b0; bus.core_wen_i = 1'b0; bus.core_byte_i = 1'b0;
        bus.core_addr_i = 12'h000; bus.core_wdata_i = 32'h0;
        bus.net_valid_i = 1'b0; bus.net_wen_i = 1'b0; bus.net_byte_i = 1'b0;
        bus.net_addr_i = 12'h000; bus.net_wdata_i = 32'h0;
        bus.mem_yumi_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    bit gq[$];
    bit exp_g[4];
    int pulses;
    int core_pulses;

    initial begin
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
        idle_inputs();
        reset = 1'b1;
        bus.core_valid_i = 1'b1;
        next_cycle();
        next_cycle();
        #2;
        chk("rst_core_ack", bus.core_ack_o, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_owner", owner, 32'h0);
        chk("rst_err", err, 32'h0);
        chk("rst_mem_valid", bus.mem_valid_o, 32'h0);

        // Core read of 0x010, yumi at cycle 1, response at cycle 3
        next_cycle();
        reset = 1'b0;
        bus.core_valid_i = 1'b1; bus.core_addr_i = 12'h010;
        #2;
        chk("rd_c0_core_ack", bus.core_ack_o, 32'h1);
        chk("rd_c0_net_ack", bus.net_ack_o, 32'h0);
        next_cycle();
        bus.core_valid_i = 1'b0; bus.mem_yumi_i = 1'b1;
        #2;
        chk("rd_c1_mem_valid", bus.mem_valid_o, 32'h1);
        chk("rd_c1_mem_addr", 32'(bus.mem_addr_o), 32'h010);
        chk("rd_c1_mem_wen", bus.mem_wen_o, 32'h0);
        next_cycle();
        bus.mem_yumi_i = 1'b0;
        #2;
        chk("rd_c2_mem_valid", bus.mem_valid_o, 32'h0);
        chk("rd_c2_busy", busy, 32'h1);
        next_cycle();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEADBEEF;
        #2;
        chk("rd_c3_core_rvalid", bus.core_rvalid_o, 32'h1);
        chk("rd_c3_core_rdata", bus.core_rdata_o, 32'hDEADBEEF);
        chk("rd_c3_net_rvalid", bus.net_rvalid_o, 32'h0);
        chk("rd_c3_mem_yumi_o", bus.mem_yumi_o, 32'h1);
        next_cycle();
        bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 32'h0;
        #2;
        chk("rd_c4_busy", busy, 32'h0);

        // Both requesters valid continuously from reset
        next_cycle();
        do_reset();
        bus.core_valid_i = 1'b1; bus.net_valid_i = 1'b1;
        bus.mem_yumi_i = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h5A5A0001;
        for (int i = 0; i < 12; i++) begin
            #2;
            if (bus.core_ack_o || bus.net_ack_o) gq.push_back(bus.net_ack_o);
            next_cycle();
        end
        idle_inputs();
        chk("rr_grant_count", 32'(gq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gq.size()) chk("rr_grant_order", 32'(gq[i]), 32'(exp_g[i]));
        end
        chk("rr_owner_last", owner, 32'h1);

        // Net byte write to 0xFFF with a 5-cycle yumi delay
        next_cycle();
        do_reset();
        pulses = 0; core_pulses = 0;
        bus.net_valid_i = 1'b1; bus.net_wen_i = 1'b1; bus.net_byte_i = 1'b1;
        bus.net_addr_i = 12'hFFF; bus.net_wdata_i = 32'h000000AB;
        #2;
        chk("sb_net_ack", bus.net_ack_o, 32'h1);
        chk("sb_core_ack", bus.core_ack_o, 32'h0);
        next_cycle();
        bus.net_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("sb_hold_valid", bus.mem_valid_o, 32'h1);
            chk("sb_hold_addr", 32'(bus.mem_addr_o), 32'h00000FFF);
            chk("sb_hold_wdata", bus.mem_wdata_o, 32'h000000AB);
            chk("sb_hold_byte", bus.mem_byte_o, 32'h1);
            pulses += int'(bus.net_rvalid_o);
            next_cycle();
        end
        bus.mem_yumi_i = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0BADF00D;
        #2;
        chk("sb_yumi_rvalid_ignored", bus.net_rvalid_o, 32'h0);
        pulses += int'(bus.net_rvalid_o);
        next_cycle();
        bus.mem_yumi_i = 1'b0;
        #2;
        chk("sb_net_rvalid", bus.net_rvalid_o, 32'h1);
        chk("sb_net_rdata", bus.net_rdata_o, 32'h0BADF00D);
        pulses += int'(bus.net_rvalid_o);
        core_pulses += int'(bus.core_rvalid_o);
        next_cycle();
        bus.mem_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            pulses += int'(bus.net_rvalid_o);
            core_pulses += int'(bus.core_rvalid_o);
            next_cycle();
        end
        chk("sb_net_pulses", 32'(pulses), 32'd1);
        chk("sb_core_pulses", 32'(core_pulses), 32'd0);

        // Memory never answers: err after TIMEOUT cycles in the acked state
        do_reset();
        bus.core_valid_i = 1'b1; bus.core_addr_i = 12'h020;
        next_cycle();
        bus.core_valid_i = 1'b0; bus.mem_yumi_i = 1'b1;
        next_cycle();
        bus.mem_yumi_i = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            #2;
            chk("to_err", err, (c >= 6) ? 32'h1 : 32'h0);
            chk("to_busy", busy, 32'h1);
            next_cycle();
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #2;
        chk("to_err_cleared", err, 32'h0);
        chk("to_busy_cleared", busy, 32'h0);

        // Reset while the command is outstanding, then a stray response
        next_cycle();
        bus.core_valid_i = 1'b1; bus.core_addr_i = 12'h030; bus.core_wdata_i = 32'h11223344;
        bus.core_wen_i = 1'b1;
        next_cycle();
        idle_inputs();
        #2;
        chk("mr_c1_mem_valid", bus.mem_valid_o, 32'h1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #2;
        chk("mr_c2_mem_valid", bus.mem_valid_o, 32'h0);
        chk("mr_c2_mem_addr", 32'(bus.mem_addr_o), 32'h0);
        chk("mr_c2_busy", busy, 32'h0);
        next_cycle();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hFFFFFFFF;
        #2;
        chk("mr_stray_core_rvalid", bus.core_rvalid_o, 32'h0);
        chk("mr_stray_core_rdata", bus.core_rdata_o, 32'h0);
        chk("mr_stray_yumi", bus.mem_yumi_o, 32'h0);
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 12 (data_mem_addr_width_gp), data memory address width.
REQ-002 Parameter: TIMEOUT, 255, maximum number of cycles allowed in DMEM_REQ_ACKED before an error is flagged.
REQ-003 The module SHALL run on one clock with synchronous, active-high reset.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-004 Ports per requester, with X = core (port 0) and X = net (port 1):
- X_valid_i  in  1  request pending.
- X_wen_i  in  1  1 = write.
- X_byte_i  in  1  byte_not_word.
- X_addr_i  in  ADDR_W  address.
- X_wdata_i  in  32  write data.
- X_ack_o  out  1  request captured.
- X_rvalid_o  out  1  response valid.
- X_rdata_o  out  32  read data.
REQ-005 Memory-side ports:
- mem_valid_o, mem_wen_o, mem_byte_o  out  1 each.
- mem_addr_o  out  ADDR_W.
- mem_wdata_o  out  32.
- mem_yumi_i  in  1  memory accepted the command.
- mem_rvalid_i  in  1  response valid.
- mem_rdata_i  in  32  read data.
- mem_yumi_o  out  1  response consumed.
REQ-006 Status ports:
- busy_o  out  1  state != DMEM_IDLE.
- owner_o  out  1  0 = core, 1 = net.
- err_o  out  1  sticky timeout flag.

Function
REQ-007 FSM states SHALL be DMEM_IDLE, DMEM_REQ_SENT and DMEM_REQ_ACKED (dmem_req_state).
REQ-008 In DMEM_IDLE, with any X_valid_i high, grant SHALL be combinational in the same cycle:
- X_ack_o pulses for 1 cycle to the winner only.
- wen, byte, addr and wdata are captured into registers.
- owner_o is updated.
- next state is DMEM_REQ_SENT.
REQ-009 Arbitration SHALL be round-robin: when both requesters are valid, grant goes to the port not granted last. last_grant resets to net, so core wins the first tie.
REQ-010 In DMEM_REQ_SENT, mem_valid_o SHALL be 1 and the mem_* command outputs SHALL be driven from the captured registers, held stable until mem_yumi_i. On mem_yumi_i the FSM moves to DMEM_REQ_ACKED.
REQ-011 mem_valid_o SHALL be 0 in every state other than DMEM_REQ_SENT.
REQ-012 In DMEM_REQ_ACKED, when mem_rvalid_i is 1 (reads and writes both return rvalid):
- owner X_rvalid_o = 1 and X_rdata_o = mem_rdata_i, combinationally.
- mem_yumi_o = 1 in the same cycle.
- next state is DMEM_IDLE.
REQ-013 The non-owner X_rvalid_o SHALL be 0 at all times. X_rdata_o SHALL be 0 whenever X_rvalid_o is 0.
REQ-014 mem_rvalid_i SHALL be ignored outside DMEM_REQ_ACKED: mem_yumi_o = 0 and no output changes.
REQ-015 New grants SHALL occur only in DMEM_IDLE. Requests arriving while busy remain pending until then; requesters hold X_valid_i until X_ack_o.
REQ-016 Minimum transaction latency:
- grant in cycle 0.
- mem_valid_o in cycle 1.
- response no earlier than cycle 2.
- next grant no earlier than cycle 3.
REQ-017 An 8-bit wait counter SHALL:
- clear on entry to DMEM_REQ_ACKED.
- increment each cycle in DMEM_REQ_ACKED without mem_rvalid_i, saturating at 255.
- set err_o when it reaches TIMEOUT.
REQ-018 err_o SHALL remain set until reset; the FSM keeps waiting (no abort).
REQ-019 If mem_yumi_i and mem_rvalid_i are both high in DMEM_REQ_SENT, rvalid SHALL be ignored that cycle. The memory re-presents rvalid in DMEM_REQ_ACKED.

Reset
REQ-020 With reset high at a clock edge, the following SHALL hold after that edge, including when reset arrives mid-transaction:
- state = DMEM_IDLE.
- last_grant = net.
- all captured registers, counter and err_o = 0.
- all outputs = 0.
- any in-flight response is dropped.
REQ-021 While reset is high, no X_ack_o SHALL be asserted.

Verification
REQ-022 Core read, addr 0x010: yumi at cycle 1, rvalid with rdata 0xDEADBEEF at cycle 3 -> core_ack_o at cycle 0, mem_valid_o at cycles 1 only, core_rvalid_o = 1 with 0xDEADBEEF at cycle 3, busy_o = 0 at cycle 4.
REQ-023 Core and net both valid continuously from reset -> grants alternate core, net, core, net; owner_o toggles on each grant.
REQ-024 Net SB, addr 0xFFF, wdata 0x000000AB, memory delays yumi 5 cycles -> mem_addr_o/mem_wdata_o/mem_byte_o = 0xFFF/0xAB/1 held stable for all 5 cycles; net_rvalid_o pulses once.
REQ-025 Memory never returns rvalid, TIMEOUT = 4 -> err_o rises after 4 cycles in DMEM_REQ_ACKED and stays high; subsequent reset clears it.
REQ-026 Reset asserted in DMEM_REQ_SENT -> mem_valid_o = 0 on the next cycle; a later stray mem_rvalid_i produces no X_rvalid_o and mem_yumi_o = 0.
